// File: rtl/btb_pkg.sv
// -----------------------------------------------------------------------------
// btb_pkg
// Shared types and helpers for the set-associative branch target buffer.
//   BTB_WIDTH       widest PC/target the storage entry can hold
//   ctr_t           2-bit saturating direction counter
//   CTR_WEAK_TAKEN  counter value given to a freshly allocated entry
//   btb_entry_t     {valid, tag, target[, ctr]} storage entry
//   pc_index/pc_tag set index and tag extraction from a PC
//   ctr_update      saturating counter step
// Optional feature macro: BTB_BIMODAL_EN (adds the per-entry counter field).
// -----------------------------------------------------------------------------
package btb_pkg;

  localparam int BTB_WIDTH = 32;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_WEAK_TAKEN = 2'b10;
  localparam ctr_t CTR_MAX        = 2'b11;
  localparam ctr_t CTR_MIN        = 2'b00;

  // Tags are stored right-aligned in a full-width field so the entry layout
  // does not depend on the set count chosen by the instantiating module.
  typedef struct packed {
    logic                 valid;
    logic [BTB_WIDTH-1:0] tag;
    logic [BTB_WIDTH-1:0] target;
`ifdef BTB_BIMODAL_EN
    ctr_t                 ctr;
`endif
  } btb_entry_t;

  localparam btb_entry_t ENTRY_CLEAR = {$bits(btb_entry_t){1'b0}};

  function automatic logic [BTB_WIDTH-1:0] pc_index(input logic [BTB_WIDTH-1:0] pc,
                                                    input int unsigned pc_offset,
                                                    input int unsigned idx_bits);
    logic [BTB_WIDTH-1:0] mask;
    mask = {BTB_WIDTH{1'b1}} >> (BTB_WIDTH - idx_bits);
    return (pc >> pc_offset) & mask;
  endfunction

  function automatic logic [BTB_WIDTH-1:0] pc_tag(input logic [BTB_WIDTH-1:0] pc,
                                                  input int unsigned pc_offset,
                                                  input int unsigned idx_bits);
    return pc >> (pc_offset + idx_bits);
  endfunction

  function automatic ctr_t ctr_update(input ctr_t ctr, input logic taken);
    ctr_t nxt;
    if (taken) begin
      nxt = (ctr == CTR_MAX) ? ctr : ctr + 2'd1;
    end else begin
      nxt = (ctr == CTR_MIN) ? ctr : ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/btb_set_repl.sv
// -----------------------------------------------------------------------------
// btb_set_repl
// Replacement state for one BTB set: picks the lowest-index invalid way, or the
// round-robin pointer when every way is valid.
//   clk, rst    clock, synchronous active-high reset
//   clear       flush: return pointer to way 0
//   advance     an allocation in this set evicted a valid entry
//   valid_bits  valid bit of each way in this set
//   victim      way to allocate into
//   full        every way of the set is valid
// -----------------------------------------------------------------------------
module btb_set_repl #(
  parameter  int NUM_WAYS = 2,
  localparam int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                advance,
  input  logic [NUM_WAYS-1:0] valid_bits,
  output logic [WAY_W-1:0]    victim,
  output logic                full
);

  logic [WAY_W-1:0] ptr_r;
  logic [WAY_W-1:0] first_free_s;

  // Priority encode the lowest invalid way; scanning downwards lets the lowest index win
  always_comb begin
    first_free_s = {WAY_W{1'b0}};
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      first_free_s = valid_bits[w] ? first_free_s : WAY_W'(w);
    end
  end

  assign full   = &valid_bits;
  assign victim = full ? ptr_r : first_free_s;

  // Round-robin pointer, moved only when a valid entry gets evicted
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ptr_r <= {WAY_W{1'b0}};
    end else if (advance) begin
      ptr_r <= (ptr_r == WAY_W'(NUM_WAYS - 1)) ? {WAY_W{1'b0}} : ptr_r + WAY_W'(1);
    end
  end

endmodule

// File: rtl/btb_assoc.sv
// -----------------------------------------------------------------------------
// btb_assoc
// Set-associative branch target buffer with one registered lookup port and one
// update port.
//   clk, rst        clock, synchronous active-high reset
//   flush           invalidate every entry and reset replacement pointers
//   lookup_valid/lookup_pc   lookup request with the fetch PC
//   pred_valid/pred_hit/pred_taken/pred_target/pred_way
//                   registered prediction, one cycle after the request
//   update_valid/update_pc/update_target/update_taken
//                   resolved branch information
// Optional feature macro: BTB_BIMODAL_EN -- per-entry 2-bit counter drives the
// direction prediction; without it a not-taken hit update invalidates the entry.
// -----------------------------------------------------------------------------
module btb_assoc
  import btb_pkg::*;
#(
  parameter  int NUM_SETS  = 8,
  parameter  int NUM_WAYS  = 2,
  parameter  int PC_OFFSET = 2,
  parameter  int WIDTH     = BTB_WIDTH,
  localparam int WAY_W     = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             lookup_valid,
  input  logic [WIDTH-1:0] lookup_pc,
  output logic             pred_valid,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [WIDTH-1:0] pred_target,
  output logic [WAY_W-1:0] pred_way,
  input  logic             update_valid,
  input  logic [WIDTH-1:0] update_pc,
  input  logic [WIDTH-1:0] update_target,
  input  logic             update_taken
);

  localparam int IDX_W = $clog2(NUM_SETS);

  btb_entry_t mem_r [NUM_SETS][NUM_WAYS];

  // lookup side
  logic [IDX_W-1:0]     lk_idx_s;
  logic [BTB_WIDTH-1:0] lk_tag_s;
  logic [NUM_WAYS-1:0]  lk_match_s;
  logic                 lk_hit_s;
  logic [WAY_W-1:0]     lk_way_s;
  logic [BTB_WIDTH-1:0] lk_target_s;
  logic                 lk_taken_s;

  // update side
  logic [IDX_W-1:0]     upd_idx_s;
  logic [BTB_WIDTH-1:0] upd_tag_s;
  logic [NUM_WAYS-1:0]  upd_match_s;
  logic                 upd_hit_s;
  logic [WAY_W-1:0]     upd_way_s;
  logic [WAY_W-1:0]     upd_victim_s;
  logic                 upd_full_s;
  logic                 upd_evict_s;
  btb_entry_t           alloc_entry_s;
`ifdef BTB_BIMODAL_EN
  ctr_t                 lk_ctr_s;
  ctr_t                 upd_ctr_s;
`endif

  // replacement state
  logic [NUM_WAYS-1:0]  set_valid_s [NUM_SETS];
  logic [WAY_W-1:0]     victim_s    [NUM_SETS];
  logic                 set_full_s  [NUM_SETS];

  // output registers
  logic                 pred_valid_r;
  logic                 pred_hit_r;
  logic                 pred_taken_r;
  logic [WIDTH-1:0]     pred_target_r;
  logic [WAY_W-1:0]     pred_way_r;

  assign lk_idx_s  = IDX_W'(pc_index(BTB_WIDTH'(lookup_pc), PC_OFFSET, IDX_W));
  assign lk_tag_s  = pc_tag(BTB_WIDTH'(lookup_pc), PC_OFFSET, IDX_W);
  assign upd_idx_s = IDX_W'(pc_index(BTB_WIDTH'(update_pc), PC_OFFSET, IDX_W));
  assign upd_tag_s = pc_tag(BTB_WIDTH'(update_pc), PC_OFFSET, IDX_W);

  // Lookup tag compare; at most one way can match so the fields are OR-reduced
  always_comb begin
    lk_match_s  = {NUM_WAYS{1'b0}};
    lk_way_s    = {WAY_W{1'b0}};
    lk_target_s = {BTB_WIDTH{1'b0}};
`ifdef BTB_BIMODAL_EN
    lk_ctr_s    = CTR_MIN;
`endif
    for (int w = 0; w < NUM_WAYS; w++) begin
      lk_match_s[w] = mem_r[lk_idx_s][w].valid && (mem_r[lk_idx_s][w].tag == lk_tag_s);
      lk_way_s      = lk_way_s | (WAY_W'(w) & {WAY_W{lk_match_s[w]}});
      lk_target_s   = lk_target_s | (mem_r[lk_idx_s][w].target & {BTB_WIDTH{lk_match_s[w]}});
`ifdef BTB_BIMODAL_EN
      lk_ctr_s      = lk_ctr_s | (mem_r[lk_idx_s][w].ctr & {2{lk_match_s[w]}});
`endif
    end
    lk_hit_s = |lk_match_s;
  end

`ifdef BTB_BIMODAL_EN
  assign lk_taken_s = lk_hit_s & lk_ctr_s[1];
`else
  assign lk_taken_s = lk_hit_s;
`endif

  // Update tag compare over the ways of the set being updated
  always_comb begin
    upd_match_s = {NUM_WAYS{1'b0}};
    upd_way_s   = {WAY_W{1'b0}};
`ifdef BTB_BIMODAL_EN
    upd_ctr_s   = CTR_MIN;
`endif
    for (int w = 0; w < NUM_WAYS; w++) begin
      upd_match_s[w] = mem_r[upd_idx_s][w].valid && (mem_r[upd_idx_s][w].tag == upd_tag_s);
      upd_way_s      = upd_way_s | (WAY_W'(w) & {WAY_W{upd_match_s[w]}});
`ifdef BTB_BIMODAL_EN
      upd_ctr_s      = upd_ctr_s | (mem_r[upd_idx_s][w].ctr & {2{upd_match_s[w]}});
`endif
    end
    upd_hit_s = |upd_match_s;
  end

  // Gather per-set valid vectors for the replacement logic
  always_comb begin
    for (int s = 0; s < NUM_SETS; s++) begin
      set_valid_s[s] = {NUM_WAYS{1'b0}};
      for (int w = 0; w < NUM_WAYS; w++) begin
        set_valid_s[s][w] = mem_r[s][w].valid;
      end
    end
  end

  assign upd_victim_s = victim_s[upd_idx_s];
  assign upd_full_s   = set_full_s[upd_idx_s];
  // Pointer only moves when a taken miss overwrites a valid entry; flush drops the update
  assign upd_evict_s  = update_valid & ~flush & ~upd_hit_s & update_taken & upd_full_s;

  for (genvar s = 0; s < NUM_SETS; s++) begin : g_repl
    btb_set_repl #(
      .NUM_WAYS (NUM_WAYS)
    ) u_repl (
      .clk        (clk),
      .rst        (rst),
      .clear      (flush),
      .advance    (upd_evict_s && (upd_idx_s == IDX_W'(s))),
      .valid_bits (set_valid_s[s]),
      .victim     (victim_s[s]),
      .full       (set_full_s[s])
    );
  end

  // Build the entry written on allocation
  always_comb begin
    alloc_entry_s        = ENTRY_CLEAR;
    alloc_entry_s.valid  = 1'b1;
    alloc_entry_s.tag    = upd_tag_s;
    alloc_entry_s.target = BTB_WIDTH'(update_target);
`ifdef BTB_BIMODAL_EN
    alloc_entry_s.ctr    = CTR_WEAK_TAKEN;
`endif
  end

  // Entry storage: reset, flush, hit update or allocation
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          mem_r[s][w] <= ENTRY_CLEAR;
        end
      end
    end else if (flush) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          mem_r[s][w].valid <= 1'b0;
        end
      end
    end else if (update_valid) begin
      if (upd_hit_s) begin
        mem_r[upd_idx_s][upd_way_s].target <= BTB_WIDTH'(update_target);
`ifdef BTB_BIMODAL_EN
        mem_r[upd_idx_s][upd_way_s].ctr <= ctr_update(upd_ctr_s, update_taken);
`else
        if (!update_taken) begin
          mem_r[upd_idx_s][upd_way_s].valid <= 1'b0;
        end
`endif
      end else if (update_taken) begin
        mem_r[upd_idx_s][upd_victim_s] <= alloc_entry_s;
      end
    end
  end

  // Registered prediction; a flush in the request cycle forces a miss
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid_r  <= 1'b0;
      pred_hit_r    <= 1'b0;
      pred_taken_r  <= 1'b0;
      pred_target_r <= {WIDTH{1'b0}};
      pred_way_r    <= {WAY_W{1'b0}};
    end else begin
      pred_valid_r <= lookup_valid;
      if (lookup_valid && !flush) begin
        pred_hit_r    <= lk_hit_s;
        pred_taken_r  <= lk_taken_s;
        pred_target_r <= WIDTH'(lk_target_s);
        pred_way_r    <= lk_way_s;
      end else begin
        pred_hit_r    <= 1'b0;
        pred_taken_r  <= 1'b0;
        pred_target_r <= {WIDTH{1'b0}};
        pred_way_r    <= {WAY_W{1'b0}};
      end
    end
  end

  assign pred_valid  = pred_valid_r;
  assign pred_hit    = pred_hit_r;
  assign pred_taken  = pred_taken_r;
  assign pred_target = pred_target_r;
  assign pred_way    = pred_way_r;

endmodule

// File: tb/tb_btb_assoc.sv
// -----------------------------------------------------------------------------
// tb_btb_assoc
// Scoreboard bench for btb_assoc with default parameters (8 sets, 2 ways).
// Each driven lookup pushes its expected prediction; a monitor pops and compares
// one cycle later. Direction expectations follow BTB_BIMODAL_EN when defined.
// -----------------------------------------------------------------------------
module tb_btb_assoc;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        pred_valid;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [0:0]  pred_way;
  logic        update_valid;
  logic [31:0] update_pc;
  logic [31:0] update_target;
  logic        update_taken;

  typedef struct {
    logic        hit;
    logic        taken;
    logic [31:0] target;
    logic [0:0]  way;
  } exp_t;

  exp_t exp_q[$];
  int   checks_cnt = 0;
  int   errors_cnt = 0;
  logic mon_issued;
  exp_t mon_exp;

  btb_assoc dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .lookup_valid  (lookup_valid),
    .lookup_pc     (lookup_pc),
    .pred_valid    (pred_valid),
    .pred_hit      (pred_hit),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .pred_way      (pred_way),
    .update_valid  (update_valid),
    .update_pc     (update_pc),
    .update_target (update_target),
    .update_taken  (update_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle of stimulus, driven on the falling edge
  task automatic step(input logic r, input logic fl,
                      input logic lv, input logic [31:0] lpc,
                      input logic uv, input logic [31:0] upc, input logic [31:0] utgt,
                      input logic utk,
                      input logic eh, input logic et, input logic [31:0] etgt,
                      input logic [0:0] ew);
    exp_t e;
    @(negedge clk);
    rst           = r;
    flush         = fl;
    lookup_valid  = lv;
    lookup_pc     = lpc;
    update_valid  = uv;
    update_pc     = upc;
    update_target = utgt;
    update_taken  = utk;
    if (lv && !r) begin
      e.hit    = eh;
      e.taken  = et;
      e.target = etgt;
      e.way    = ew;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, pc, tgt, tk, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic lk(input logic [31:0] pc, input logic eh, input logic et,
                    input logic [31:0] etgt, input logic [0:0] ew);
    step(1'b0, 1'b0, 1'b1, pc, 1'b0, 32'h0, 32'h0, 1'b0, eh, et, etgt, ew);
  endtask

  task automatic lk_miss(input logic [31:0] pc);
    lk(pc, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic lk_hit(input logic [31:0] pc, input logic [31:0] tgt, input logic [0:0] way);
    lk(pc, 1'b1, 1'b1, tgt, way);
  endtask

  // Monitor: compare every cycle's outputs just after the rising edge
  always @(posedge clk) begin
    mon_issued = lookup_valid && !rst;
    #1;
    check_val("pred_valid", {63'h0, pred_valid}, {63'h0, mon_issued});
    if (mon_issued) begin
      check_val("sb_nonempty", {63'h0, exp_q.size() != 0}, 64'h1);
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        check_val("pred_hit",    {63'h0, pred_hit},    {63'h0, mon_exp.hit});
        check_val("pred_taken",  {63'h0, pred_taken},  {63'h0, mon_exp.taken});
        check_val("pred_target", {32'h0, pred_target}, {32'h0, mon_exp.target});
        check_val("pred_way",    {63'h0, pred_way},    {63'h0, mon_exp.way});
      end
    end else begin
      check_val("idle_hit",    {63'h0, pred_hit},    64'h0);
      check_val("idle_taken",  {63'h0, pred_taken},  64'h0);
      check_val("idle_target", {32'h0, pred_target}, 64'h0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    flush         = 1'b0;
    lookup_valid  = 1'b1;
    lookup_pc     = 32'h0000_1000;
    update_valid  = 1'b0;
    update_pc     = 32'h0;
    update_target = 32'h0;
    update_taken  = 1'b0;
    // Reset with a lookup pending: it must be discarded
    step(1'b1, 1'b0, 1'b1, 32'h1000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    idle();

    // Empty BTB misses
    lk_miss(32'h1000);

    // First allocation into set 0, way 0; different tag in same set misses
    upd(32'h1000, 32'h2000, 1'b1);
    lk_hit(32'h1000, 32'h2000, 1'b0);
    lk_miss(32'h1020);

    // Fill set 0, then round-robin eviction
    upd(32'h1020, 32'h2020, 1'b1);
    upd(32'h1040, 32'h2040, 1'b1);
    lk_miss(32'h1000);
    lk_hit(32'h1020, 32'h2020, 1'b1);
    lk_hit(32'h1040, 32'h2040, 1'b0);
    upd(32'h1060, 32'h2060, 1'b1);
    lk_miss(32'h1020);
    lk_hit(32'h1060, 32'h2060, 1'b1);
    lk_hit(32'h1040, 32'h2040, 1'b0);

    // Hit update overwrites the target in place; not-taken miss changes nothing
    upd(32'h1040, 32'h2044, 1'b1);
    lk_hit(32'h1040, 32'h2044, 1'b0);
    upd(32'h1080, 32'h2080, 1'b0);
    lk_miss(32'h1080);
    lk_hit(32'h1060, 32'h2060, 1'b1);

    // Same-cycle lookup and update: lookup sees old contents; pointer is at way 0
    step(1'b0, 1'b0, 1'b1, 32'h3000, 1'b1, 32'h3000, 32'h3300, 1'b1,
         1'b0, 1'b0, 32'h0, 1'b0);
    lk_hit(32'h3000, 32'h3300, 1'b0);
    lk_hit(32'h1060, 32'h2060, 1'b1);
    lk_miss(32'h1040);

    // Direction handling on set 1
    upd(32'h1004, 32'h4000, 1'b1);
    lk_hit(32'h1004, 32'h4000, 1'b0);
    upd(32'h1004, 32'h4000, 1'b0);
`ifdef BTB_BIMODAL_EN
    lk(32'h1004, 1'b1, 1'b0, 32'h4000, 1'b0);
    upd(32'h1004, 32'h4000, 1'b0);
    lk(32'h1004, 1'b1, 1'b0, 32'h4000, 1'b0);
    upd(32'h1004, 32'h4000, 1'b1);
    lk(32'h1004, 1'b1, 1'b0, 32'h4000, 1'b0);
    upd(32'h1004, 32'h4000, 1'b1);
    lk(32'h1004, 1'b1, 1'b1, 32'h4000, 1'b0);
`else
    lk_miss(32'h1004);
`endif

    // Populate sets 2..5, then flush with a concurrent update and lookup
    upd(32'h1008, 32'h5008, 1'b1);
    upd(32'h100C, 32'h500C, 1'b1);
    upd(32'h1010, 32'h5010, 1'b1);
    upd(32'h1014, 32'h5014, 1'b1);
    lk_hit(32'h1010, 32'h5010, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h1008, 1'b1, 32'h5000, 32'h6000, 1'b1,
         1'b0, 1'b0, 32'h0, 1'b0);
    lk_miss(32'h1008);
    lk_miss(32'h100C);
    lk_miss(32'h1010);
    lk_miss(32'h1014);
    lk_miss(32'h5000);
    lk_miss(32'h3000);

    // Flush also reset set 0's pointer: third allocation evicts way 0
    upd(32'h1000, 32'h7000, 1'b1);
    upd(32'h1020, 32'h7020, 1'b1);
    upd(32'h1040, 32'h7040, 1'b1);
    lk_hit(32'h1040, 32'h7040, 1'b0);
    lk_hit(32'h1020, 32'h7020, 1'b1);
    lk_miss(32'h1000);

    // Reset mid-operation with a concurrent lookup, then BTB is empty
    step(1'b1, 1'b0, 1'b1, 32'h1040, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    lk_miss(32'h1040);
    lk_miss(32'h1020);
    idle();
    idle();

    check_val("sb_drained", 64'(exp_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
